// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
package sync_fifo_pkg;

    // Per-cycle transfer kind, built as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Circular increment that is valid for any depth, not only powers of two.
    function automatic int unsigned wrap_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port, one read port.
// FWFT=0 gives a registered read (reset to zero), FWFT=1 an asynchronous read.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = 0,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_read
            // Read enable and reset only matter for the registered read path.
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = re ^ rst_n;
            assign rdata = mem[raddr];
        end else begin : g_sync_read
            logic [WIDTH-1:0] rdata_q;

            // Registered read: captures the addressed word on a read, otherwise holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, optional first-word-fall-through read,
// synchronous flush and sticky overflow/underflow flags.
//
// Handshake: a write is accepted when write=1 and full=0; a read is accepted
// when read=1 and empty=0. Rejected requests are dropped and set the matching
// sticky flag. With both requests on a full FIFO only the read is taken, and on
// an empty FIFO only the write is taken; there is no pass-through path.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       write,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       read,
    output logic [WIDTH-1:0]           read_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    // Configuration sanity: thresholds must lie within 0..DEPTH.
    generate
        if (AFULL_TH < 0 || AFULL_TH > DEPTH) begin : g_bad_afull
            $error("sync_fifo: AFULL_TH=%0d outside 0..DEPTH=%0d", AFULL_TH, DEPTH);
        end
        if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_bad_aempty
            $error("sync_fifo: AEMPTY_TH=%0d outside 0..DEPTH=%0d", AEMPTY_TH, DEPTH);
        end
        if (DEPTH < 2 || WIDTH < 1) begin : g_bad_size
            $error("sync_fifo: DEPTH must be >= 2 and WIDTH >= 1");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             wr_acc;
    logic             rd_acc;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    fifo_op_e         op;
    logic [WIDTH-1:0] mem_rdata;

    // Flags decode straight from the registered count.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = write & ~full;
    assign rd_acc = read & ~empty;

    // Next-pointer and transfer-kind decode.
    always_comb begin
        wr_ptr_nxt = PTR_W'(wrap_next(32'(wr_ptr_q), DEPTH));
        rd_ptr_nxt = PTR_W'(rd_ptr_q == PTR_W'(DEPTH - 1) ? 0 : 32'(rd_ptr_q) + 1);
        op         = fifo_op_e'({wr_acc, rd_acc});
    end

    // Pointer, occupancy and sticky-flag state; flush outranks any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_nxt;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case (op)
                OP_WRITE: count_q <= count_q + 1'b1;
                OP_READ:  count_q <= count_q - 1'b1;
                default:  count_q <= count_q;
            endcase
            if (write && full) begin
                overflow_q <= 1'b1;
            end
            if (read && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FWFT  (FWFT),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr_q),
        .wdata (write_data),
        .re    (rd_acc & ~flush),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // In FWFT mode the head word is only presented while something is stored.
    generate
        if (FWFT != 0) begin : g_fwft_out
            assign read_data = empty ? '0 : mem_rdata;
        end else begin : g_reg_out
            assign read_data = mem_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: DEPTH=16 registered read, DEPTH=5 with
// pointer wrap, and DEPTH=16 first-word-fall-through.
module tb_sync_fifo;

    logic clk;
    logic rst_n;

    // DEPTH=16, FWFT=0
    logic       a_flush, a_write, a_read;
    logic [7:0] a_wd, a_rd;
    logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
    logic [4:0] a_count;

    // DEPTH=5, FWFT=0
    logic       b_flush, b_write, b_read;
    logic [7:0] b_wd, b_rd;
    logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
    logic [2:0] b_count;

    // DEPTH=16, FWFT=1
    logic       c_flush, c_write, c_read;
    logic [7:0] c_wd, c_rd;
    logic       c_full, c_empty, c_afull, c_aempty, c_ovf, c_unf;
    logic [4:0] c_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .write(a_write), .write_data(a_wd),
        .read(a_read), .read_data(a_rd), .full(a_full), .empty(a_empty),
        .almost_full(a_afull), .almost_empty(a_aempty), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .write(b_write), .write_data(b_wd),
        .read(b_read), .read_data(b_rd), .full(b_full), .empty(b_empty),
        .almost_full(b_afull), .almost_empty(b_aempty), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .write(c_write), .write_data(c_wd),
        .read(c_read), .read_data(c_rd), .full(c_full), .empty(c_empty),
        .almost_full(c_afull), .almost_empty(c_aempty), .count(c_count),
        .overflow(c_ovf), .underflow(c_unf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] n;
        logic [7:0] e;

        rst_n   = 1'b0;
        a_flush = 0; a_write = 0; a_read = 0; a_wd = 0;
        b_flush = 0; b_write = 0; b_read = 0; b_wd = 0;
        c_flush = 0; c_write = 0; c_read = 0; c_wd = 0;
        cyc();
        cyc();

        // Reset state
        chk("rst_count", 32'(a_count), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_aempty", 32'(a_aempty), 1);
        chk("rst_afull", 32'(a_afull), 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_unf", 32'(a_unf), 0);
        chk("rst_rdata", 32'(a_rd), 0);
        chk("rst_c_rdata", 32'(c_rd), 0);
        rst_n = 1'b1;
        cyc();

        // Fill 16 words
        for (int i = 0; i < 16; i++) begin
            a_write = 1; a_wd = 8'(i);
            cyc();
            chk("fill_count", 32'(a_count), 32'(i + 1));
            chk("fill_afull", 32'(a_afull), (i + 1 >= 14) ? 1 : 0);
            chk("fill_aempty", 32'(a_aempty), (i + 1 <= 2) ? 1 : 0);
            chk("fill_full", 32'(a_full), (i + 1 == 16) ? 1 : 0);
        end
        a_wd = 8'h55;
        cyc();
        a_write = 0;
        chk("ovf_count", 32'(a_count), 16);
        chk("ovf_flag", 32'(a_ovf), 1);
        chk("ovf_unf", 32'(a_unf), 0);

        // Drain 16 words
        for (int i = 0; i < 16; i++) begin
            a_read = 1;
            cyc();
            chk("drain_data", 32'(a_rd), 32'(i));
            chk("drain_count", 32'(a_count), 32'(15 - i));
        end
        chk("drain_empty", 32'(a_empty), 1);
        cyc();
        a_read = 0;
        chk("unf_flag", 32'(a_unf), 1);
        chk("unf_hold", 32'(a_rd), 8'h0F);
        chk("unf_count", 32'(a_count), 0);
        chk("unf_ovf_sticky", 32'(a_ovf), 1);

        // Flush clears sticky flags, read register holds
        a_flush = 1;
        cyc();
        a_flush = 0;
        chk("flush1_ovf", 32'(a_ovf), 0);
        chk("flush1_unf", 32'(a_unf), 0);
        chk("flush1_rdata", 32'(a_rd), 8'h0F);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            a_write = 1; a_wd = 8'(8'h20 + i);
            cyc();
        end
        a_read = 1; a_wd = 8'hEE;
        cyc();
        a_write = 0;
        chk("frw_count", 32'(a_count), 15);
        chk("frw_ovf", 32'(a_ovf), 1);
        chk("frw_data", 32'(a_rd), 8'h20);
        for (int i = 1; i < 16; i++) begin
            cyc();
            chk("frw_drain", 32'(a_rd), 32'(8'h20 + i));
        end
        a_read = 0;
        chk("frw_empty", 32'(a_empty), 1);
        chk("frw_unf", 32'(a_unf), 0);

        // Empty FIFO with simultaneous read and write
        a_write = 1; a_read = 1; a_wd = 8'h77;
        cyc();
        a_write = 0; a_read = 0;
        chk("erw_count", 32'(a_count), 1);
        chk("erw_unf", 32'(a_unf), 1);
        chk("erw_hold", 32'(a_rd), 8'h2F);
        a_read = 1;
        cyc();
        a_read = 0;
        chk("erw_data", 32'(a_rd), 8'h77);

        // Flush with count=7, both flags set, write asserted
        for (int i = 0; i < 7; i++) begin
            a_write = 1; a_wd = 8'(8'h40 + i);
            cyc();
        end
        a_write = 0;
        chk("pre_flush_count", 32'(a_count), 7);
        chk("pre_flush_ovf", 32'(a_ovf), 1);
        chk("pre_flush_unf", 32'(a_unf), 1);
        a_flush = 1; a_write = 1; a_wd = 8'h99;
        cyc();
        a_flush = 0; a_write = 0;
        chk("flush_count", 32'(a_count), 0);
        chk("flush_empty", 32'(a_empty), 1);
        chk("flush_ovf", 32'(a_ovf), 0);
        chk("flush_unf", 32'(a_unf), 0);

        // DEPTH=5: three writes, two reads, four rounds through the wrap
        n = 8'h10;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                b_write = 1; b_wd = n;
                if (exp_q.size() < 5) exp_q.push_back(n);
                n = n + 8'd1;
                cyc();
                b_write = 0;
                chk("d5_count", 32'(b_count), 32'(exp_q.size()));
                chk("d5_full", 32'(b_full), (exp_q.size() == 5) ? 1 : 0);
            end
            for (int k = 0; k < 2; k++) begin
                b_read = 1;
                cyc();
                b_read = 0;
                e = exp_q.pop_front();
                chk("d5_data", 32'(b_rd), 32'(e));
                chk("d5_rcount", 32'(b_count), 32'(exp_q.size()));
            end
        end
        chk("d5_ovf", 32'(b_ovf), 1);
        chk("d5_afull", 32'(b_afull), (exp_q.size() >= 3) ? 1 : 0);

        // FWFT
        chk("fwft_empty_data", 32'(c_rd), 0);
        c_write = 1; c_wd = 8'hA5;
        cyc();
        c_write = 0;
        chk("fwft_head", 32'(c_rd), 8'hA5);
        cyc();
        chk("fwft_hold", 32'(c_rd), 8'hA5);
        c_write = 1; c_wd = 8'h3C;
        cyc();
        c_write = 0;
        chk("fwft_head2", 32'(c_rd), 8'hA5);
        c_read = 1;
        cyc();
        c_read = 0;
        chk("fwft_next", 32'(c_rd), 8'h3C);
        chk("fwft_count", 32'(c_count), 1);
        c_read = 1;
        cyc();
        c_read = 0;
        chk("fwft_empty", 32'(c_empty), 1);
        chk("fwft_zero", 32'(c_rd), 0);

        // Asynchronous reset in the middle of a burst
        a_write = 1; a_wd = 8'h11;
        c_write = 1; c_wd = 8'h22;
        cyc();
        cyc();
        chk("burst_count", 32'(a_count), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_a_count", 32'(a_count), 0);
        chk("arst_b_count", 32'(b_count), 0);
        chk("arst_c_count", 32'(c_count), 0);
        chk("arst_a_rdata", 32'(a_rd), 0);
        chk("arst_b_ovf", 32'(b_ovf), 0);
        chk("arst_c_empty", 32'(c_empty), 1);
        a_write = 0; c_write = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_count", 32'(a_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO, the successor to the peripheral-level byte FIFO used by the UART/SPI blocks. It adds the following over the original:
- all DEPTH entries usable, with an occupancy count;
- programmable almost-full and almost-empty flags;
- selectable first-word-fall-through (FWFT) read mode;
- synchronous flush;
- sticky overflow and underflow flags.

It sits between bus-side register logic and serial peripheral engines.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of storage entries (>=2, need not be a power of two).
- FWFT, 0: 0 = registered read (data one cycle after read); 1 = head word visible on read_data while not empty.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.
- Derived (localparam): PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents and sticky flags.
- write  in  1  write request.
- write_data  in  WIDTH  data to push.
- read  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- read_data  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, registered read_data=0. Storage contents are not reset.
- Reset takes effect mid-operation, on any cycle; all state returns to reset values with no partial transfer.
- Flag outputs (full, empty, almost_*) are combinational decodes of the registered count; no extra latency.
- Write accept: wr_acc = write & ~full. The word is stored at wr_ptr and wr_ptr advances.
- Read accept: rd_acc = read & ~empty. rd_ptr advances.
- Pointer wrap: ptr == DEPTH-1 -> 0, otherwise ptr+1. Correct for non-power-of-two DEPTH.
- Count update per cycle: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- Simultaneous read+write when full: read accepted, write rejected (no pass-through). count becomes DEPTH-1 and overflow is set.
- Simultaneous read+write when empty: write accepted, read rejected. count becomes 1 and underflow is set.
- Simultaneous read+write otherwise: both accepted; count unchanged.
- FWFT=0: on rd_acc, read_data <= mem[rd_ptr] at that edge, so data is valid the cycle after the request. read_data holds its value when there is no rd_acc.
- FWFT=1: read_data = mem[rd_ptr] combinationally while ~empty, otherwise 0. A word written into an empty FIFO appears the cycle after its write edge. rd_acc moves to the next word.
- overflow and underflow stay set until flush or reset.
- Flush (synchronous, highest priority over write/read in the same cycle): pointers=0, count=0, sticky flags=0. Any write/read in that cycle is discarded and does not set the flags. The FWFT=0 read_data register is left unchanged.
- Threshold parameters outside 0..DEPTH are a configuration error; an elaboration-time check reports it.

Decomposition:
- No shared package needed.
- PTR_W/CNT_W are localparams computed inside the block. Threshold defaults are derived from DEPTH.
- Optional sub-module sync_fifo_mem: simple dual-port array with one write port, sync read for FWFT=0 and async read for FWFT=1. It keeps storage inferable as distributed/block RAM separately from the control logic.

Test Plan:
- DEPTH=16, FWFT=0: write 16 words 0x00..0x0F. Expect full=1, count=16, almost_full from count 14. A 17th write leaves count=16 and sets overflow=1.
- Continue the previous case: read 16 times. Expect read_data = 0x00..0x0F, each one cycle after its read, then empty=1. A further read sets underflow=1 and read_data holds 0x0F.
- DEPTH=5 (non-power-of-two): 3 writes, 2 reads, repeated 4 times. Expect in-order data through pointer wrap; count never exceeds 5; full asserts exactly at count=5.
- Full FIFO with read&write in the same cycle: expect count 16 -> 15, overflow=1, and the new word is not stored. Empty FIFO with read&write: expect count=1, underflow=1.
- FWFT=1: write 0xA5 into empty. Expect read_data=0xA5 the next cycle with read low. Write 0x3C, pulse read: read_data=0x3C the following cycle; a second read gives empty=1.
- With count=7 and both sticky flags set, assert flush together with write=1. Expect count=0, empty=1, overflow=underflow=0 on the next cycle. Asserting rst_n=0 mid-burst clears state immediately, without waiting for a clock edge.
